// File: rtl/matmul_stream_engine.sv
// matmul_stream_engine: byte-stream square matrix multiplier with one MAC.
// Ports: clk, rst (async active-low), clear, in_* byte sink, out_* byte source,
//        busy/done/err status, state (IDLE=0 LOAD_A=1 LOAD_B=2 COMPUTE=3 SEND=4 ERR=5).
module matmul_stream_engine #(
    parameter int         N_MAX    = 4,
    parameter int         ACC_W    = 24,
    parameter int         SIGNED   = 0,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    localparam int DEPTH = N_MAX * N_MAX;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int NW    = $clog2(N_MAX + 1);
    localparam int BPE   = ACC_W / 8;
    localparam int BW    = (BPE > 1) ? $clog2(BPE) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_A  = 3'd1;
    localparam logic [2:0] S_LOAD_B  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_SEND    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    logic [2:0]       st;
    logic [NW-1:0]    n_q;
    logic [IW-1:0]    last;
    logic [IW-1:0]    row;
    logic [IW-1:0]    col;
    logic [IW-1:0]    ci;
    logic [IW-1:0]    cj;
    logic [IW-1:0]    ck;
    logic [BW-1:0]    bi;
    logic [ACC_W-1:0] acc;

    logic [7:0]       a_mem [DEPTH];
    logic [7:0]       b_mem [DEPTH];
    logic [ACC_W-1:0] c_mem [DEPTH];

    logic             take;
    logic             row_last;
    logic             col_last;
    logic             byte_last;
    logic             send_last;
    logic [7:0]       a_op;
    logic [7:0]       b_op;
    logic [15:0]      prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [IW-1:0]    nrow;
    logic [IW-1:0]    ncol;
    logic [BW-1:0]    nbi;
    logic [7:0]       nbyte;
    logic [7:0]       first_byte;
    logic             size_ok;

    function automatic logic [AW-1:0] addr(
        input logic [IW-1:0] r,
        input logic [IW-1:0] c
    );
        return AW'(int'(r) * N_MAX + int'(c));
    endfunction

    // Byte b of an element, b=0 being the most significant byte.
    function automatic logic [7:0] byte_of(
        input logic [ACC_W-1:0] e,
        input logic [BW-1:0]    b
    );
        logic [ACC_W-1:0] sh;
        sh = e >> (8 * (BPE - 1 - int'(b)));
        return sh[7:0];
    endfunction

    assign in_ready = (st == S_IDLE) || (st == S_LOAD_A) || (st == S_LOAD_B);
    assign busy     = (st == S_COMPUTE) || (st == S_SEND) || (st == S_ERR);
    assign state    = st;
    assign take     = in_valid && in_ready;

    assign last      = IW'(n_q - 1'b1);
    assign row_last  = (row == last);
    assign col_last  = (col == last);
    assign byte_last = (bi == BW'(BPE - 1));
    assign send_last = row_last && col_last && byte_last;
    assign size_ok   = (in_data != 8'd0) && (int'(in_data) <= N_MAX);

    assign a_op = a_mem[addr(ci, ck)];
    assign b_op = b_mem[addr(ck, cj)];

    always_comb begin
        if (SIGNED != 0) begin
            prod     = {{8{a_op[7]}}, a_op} * {{8{b_op[7]}}, b_op};
            prod_ext = {{(ACC_W-16){prod[15]}}, prod};
        end else begin
            prod     = {8'd0, a_op} * {8'd0, b_op};
            prod_ext = {{(ACC_W-16){1'b0}}, prod};
        end
        sum = ((ck == '0) ? '0 : acc) + prod_ext;
    end

    // Position of the byte that follows the current one in SEND.
    always_comb begin
        nbi  = bi + 1'b1;
        nrow = row;
        ncol = col;
        if (byte_last) begin
            nbi = '0;
            if (col_last) begin
                ncol = '0;
                nrow = row + 1'b1;
            end else begin
                ncol = col + 1'b1;
            end
        end
        nbyte = byte_of(c_mem[addr(nrow, ncol)], nbi);
    end

    // For n=1 the only element is written in the same cycle SEND is entered.
    assign first_byte = byte_of((n_q == NW'(1)) ? sum : c_mem[0], '0);

    always_ff @(posedge clk) begin
        if (st == S_LOAD_A && take) begin
            a_mem[addr(row, col)] <= in_data;
        end
        if (st == S_LOAD_B && take) begin
            b_mem[addr(row, col)] <= in_data;
        end
        if (st == S_COMPUTE && ck == last) begin
            c_mem[addr(ci, cj)] <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= S_IDLE;
            n_q       <= '0;
            row       <= '0;
            col       <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            bi        <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (clear) begin
            st        <= S_IDLE;
            n_q       <= '0;
            row       <= '0;
            col       <= '0;
            ci        <= '0;
            cj        <= '0;
            ck        <= '0;
            bi        <= '0;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (take) begin
                        row <= '0;
                        col <= '0;
                        if (size_ok) begin
                            n_q <= NW'(in_data);
                            st  <= S_LOAD_A;
                        end else begin
                            st        <= S_ERR;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            out_data  <= ERR_BYTE;
                        end
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (take) begin
                        if (col_last) begin
                            col <= '0;
                            if (row_last) begin
                                row <= '0;
                                st  <= (st == S_LOAD_A) ? S_LOAD_B : S_COMPUTE;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc <= sum;
                    if (ck == last) begin
                        ck <= '0;
                        if (cj == last) begin
                            cj <= '0;
                            if (ci == last) begin
                                ci        <= '0;
                                st        <= S_SEND;
                                out_valid <= 1'b1;
                                out_data  <= first_byte;
                            end else begin
                                ci <= ci + 1'b1;
                            end
                        end else begin
                            cj <= cj + 1'b1;
                        end
                    end else begin
                        ck <= ck + 1'b1;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (send_last) begin
                            st        <= S_IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            done      <= 1'b1;
                            row       <= '0;
                            col       <= '0;
                            bi        <= '0;
                        end else begin
                            row      <= nrow;
                            col      <= ncol;
                            bi       <= nbi;
                            out_data <= nbyte;
                        end
                    end
                end
                S_ERR: begin
                    if (out_ready) begin
                        st        <= S_IDLE;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                    end
                end
                default: begin
                    st        <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_stream_engine.sv
// tb_matmul_stream_engine: random and directed jobs against a reference model.
// Two instances (unsigned and signed) share clock, reset, clear and data.
module tb_matmul_stream_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       u_ir, u_ov, u_busy, u_done, u_err;
    logic [7:0] u_od;
    logic [2:0] u_st;
    logic       s_ir, s_ov, s_busy, s_done, s_err;
    logic [7:0] s_od;
    logic [2:0] s_st;
    logic       u_iv, s_iv;

    logic       ir, ov, bsy, dn, er;
    logic [7:0] od;
    logic [2:0] st;

    int total = 0;
    int bad   = 0;

    logic [7:0] a_m [16];
    logic [7:0] b_m [16];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    always #5 clk = ~clk;

    assign u_iv = in_valid & ~sel;
    assign s_iv = in_valid & sel;
    assign ir   = sel ? s_ir   : u_ir;
    assign ov   = sel ? s_ov   : u_ov;
    assign bsy  = sel ? s_busy : u_busy;
    assign dn   = sel ? s_done : u_done;
    assign er   = sel ? s_err  : u_err;
    assign od   = sel ? s_od   : u_od;
    assign st   = sel ? s_st   : u_st;

    matmul_stream_engine #(.N_MAX(4), .ACC_W(24), .SIGNED(0), .ERR_BYTE(8'hEE)) u_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(u_iv), .in_ready(u_ir),
        .out_data(u_od), .out_valid(u_ov), .out_ready(out_ready),
        .busy(u_busy), .done(u_done), .err(u_err), .state(u_st)
    );

    matmul_stream_engine #(.N_MAX(4), .ACC_W(24), .SIGNED(1), .ERR_BYTE(8'hEE)) s_dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_data(in_data), .in_valid(s_iv), .in_ready(s_ir),
        .out_data(s_od), .out_valid(s_ov), .out_ready(out_ready),
        .busy(s_busy), .done(s_done), .err(s_err), .state(s_st)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // C = A*B from the stream layout, truncated to 24 bits, MSB first.
    task automatic build_exp(input int n, input bit sgn);
        int         s, x, y;
        logic [23:0] r;
        exp_q.delete();
        if (n < 1 || n > 4) begin
            exp_q.push_back(8'hEE);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = 0;
                for (int k = 0; k < n; k++) begin
                    x = sgn ? int'($signed(a_m[i*n+k])) : int'(a_m[i*n+k]);
                    y = sgn ? int'($signed(b_m[k*n+j])) : int'(b_m[k*n+j]);
                    s = s + x * y;
                end
                r = s[23:0];
                exp_q.push_back(r[23:16]);
                exp_q.push_back(r[15:8]);
                exp_q.push_back(r[7:0]);
            end
        end
    endtask

    task automatic run_job(input int n, input bit sgn, input bit bp, input bit gaps);
        logic [7:0] inq [$];
        logic [7:0] pdata = 8'd0;
        int  dcnt = 0, ecnt = 0, ccnt = 0, scnt = 0, cyc = 0;
        bit  fin = 0, hold = 0, ok;
        ok = (n >= 1 && n <= 4);
        build_exp(n, sgn);
        sel = sgn;
        inq.push_back(n[7:0]);
        if (ok) begin
            for (int x = 0; x < n*n; x++) inq.push_back(a_m[x]);
            for (int x = 0; x < n*n; x++) inq.push_back(b_m[x]);
        end
        got_q.delete();
        forever begin
            @(negedge clk);
            cyc++;
            if (dn) dcnt++;
            if (er) begin
                ecnt++;
                chk("err_state", 32'(st), 32'd5);
            end
            if (st == 3'd3) ccnt++;
            if (st == 3'd4) scnt++;
            if (hold && ov) chk("stable", 32'(od), 32'(pdata));
            if (fin) begin
                chk("done_after", 32'(dn), ok ? 32'd1 : 32'd0);
                chk("idle_after", 32'(st), 32'd0);
                chk("ov_after", 32'(ov), 32'd0);
                break;
            end
            if (cyc > 3000) begin
                chk("timeout", 32'(cyc), 32'd0);
                break;
            end
            if (inq.size() > 0 && ir && (!gaps || ($urandom % 4) != 0)) begin
                in_valid = 1'b1;
                in_data  = inq.pop_front();
            end else if (inq.size() == 0 && !ir && ($urandom % 2) == 1) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = bp ? 1'($urandom) : 1'b1;
            if (ov && out_ready) begin
                got_q.push_back(od);
                if (got_q.size() == exp_q.size()) fin = 1;
            end
            hold  = ov && !out_ready;
            pdata = od;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
        for (int x = 0; x < exp_q.size() && x < got_q.size(); x++)
            chk($sformatf("byte%0d", x), 32'(got_q[x]), 32'(exp_q[x]));
        chk("done_cnt", 32'(dcnt), ok ? 32'd1 : 32'd0);
        chk("err_cnt", 32'(ecnt), ok ? 32'd0 : 32'd1);
        if (ok) chk("compute_cyc", 32'(ccnt), 32'(n*n*n));
        if (ok && !bp) chk("send_cyc", 32'(scnt), 32'(n*n*3));
    endtask

    task automatic put_byte(input logic [7:0] b);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic set_2x2();
        for (int x = 0; x < 4; x++) begin
            a_m[x] = 8'(x + 1);
            b_m[x] = 8'(x + 5);
        end
    endtask

    initial begin
        int n, w, dsum;
        rst       = 1'b0;
        clear     = 1'b0;
        sel       = 1'b0;
        in_data   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_ov", 32'(ov), 32'd0);
        chk("rst_od", 32'(od), 32'd0);
        chk("rst_busy", 32'(bsy), 32'd0);
        chk("rst_done", 32'(dn), 32'd0);
        chk("rst_err", 32'(er), 32'd0);
        chk("rst_inready", 32'(ir), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        set_2x2();
        run_job(2, 1'b0, 1'b0, 1'b0);

        for (int x = 0; x < 16; x++) begin
            a_m[x] = 8'hFF;
            b_m[x] = 8'hFF;
        end
        run_job(4, 1'b0, 1'b0, 1'b0);

        a_m[0] = 8'hFF; b_m[0] = 8'h02;
        run_job(1, 1'b1, 1'b0, 1'b0);
        a_m[0] = 8'h80; b_m[0] = 8'h80;
        run_job(1, 1'b1, 1'b0, 1'b0);

        run_job(0, 1'b0, 1'b0, 1'b0);
        run_job(5, 1'b0, 1'b0, 1'b0);
        set_2x2();
        run_job(2, 1'b0, 1'b0, 1'b0);

        run_job(2, 1'b0, 1'b1, 1'b1);

        // clear during LOAD_B
        sel = 1'b0;
        put_byte(8'd2);
        for (int x = 0; x < 4; x++) put_byte(a_m[x]);
        for (int x = 0; x < 2; x++) put_byte(b_m[x]);
        chk("clr_in_loadb", 32'(st), 32'd2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_state", 32'(st), 32'd0);
        chk("clr_ov", 32'(ov), 32'd0);
        chk("clr_done", 32'(dn), 32'd0);
        run_job(2, 1'b0, 1'b0, 1'b0);

        // reset during SEND
        out_ready = 1'b0;
        put_byte(8'd2);
        for (int x = 0; x < 4; x++) put_byte(a_m[x]);
        for (int x = 0; x < 4; x++) put_byte(b_m[x]);
        w = 0;
        while (st != 3'd4 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rst_in_send", 32'(st), 32'd4);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(st), 32'd0);
        chk("arst_ov", 32'(ov), 32'd0);
        chk("arst_busy", 32'(bsy), 32'd0);
        dsum = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int x = 0; x < 4; x++) begin
            @(negedge clk);
            dsum += int'(dn);
        end
        chk("arst_nodone", 32'(dsum), 32'd0);
        run_job(2, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 4);
            for (int x = 0; x < 16; x++) begin
                a_m[x] = 8'($urandom);
                b_m[x] = 8'($urandom);
            end
            run_job(n, 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_stream_engine.md
# matmul_stream_engine

Parametrised successor to the UART matrix-multiply datapath. It accepts a byte stream carrying a matrix dimension and two square matrices, multiplies them with a single sequential MAC, and streams the result back as bytes under a valid/ready handshake. It sits between the UART receiver (byte + valid) and the UART transmitter (byte + start/busy adapter), and replaces the ad-hoc memories and control unit with one self-contained block.

## Interface
- N_MAX, 4: largest supported dimension n; buffers are N_MAX*N_MAX entries.
- ACC_W, 24: result element width; multiple of 8, ≥ 16 + clog2(N_MAX).
- SIGNED, 0: 0 means elements are unsigned bytes; 1 means elements are two's complement bytes and products are sign-extended.
- ERR_BYTE, 8'hEE: byte emitted when a size is rejected.
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset; all state clears while rst=0.
- clear  in  1  synchronous abort; returns to IDLE next cycle, dropping partial data.
- in_data  in  8  received byte.
- in_valid  in  1  in_data is valid this cycle; each valid cycle is one byte.
- in_ready  out  1  combinational; 1 in IDLE, LOAD_A, LOAD_B.
- out_data  out  8  result byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data this cycle.
- busy  out  1  1 in COMPUTE, SEND, ERR.
- done  out  1  one-cycle pulse on acceptance of the last result byte.
- err  out  1  one-cycle pulse when a size byte is rejected.
- state  out  3  IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, SEND=4, ERR=5.

## Operation
- Stream format: a size byte n, then n*n A bytes in row-major order, then n*n B bytes in row-major order.
- A byte is consumed only when in_valid && in_ready. Bytes offered while in_ready=0 are ignored and not buffered.
- IDLE: when the size byte is consumed:
  - if 1 ≤ n ≤ N_MAX, latch n and go to LOAD_A;
  - otherwise go to ERR and pulse err.
- LOAD_A / LOAD_B: a write index runs 0..n*n-1 and stores at buffer address row*N_MAX+col. On the last byte, go to the next state.
- COMPUTE: loop counters i, j, k are nested as i (outer), j, k (inner).
  - Each cycle, acc ← (k==0 ? 0 : acc) + A[i][k]*B[k][j].
  - When k==n-1, the new sum is written to C[i][j].
  - After i=j=k=n-1, go to SEND.
- Arithmetic: 8×8 product is 16 bits, zero- or sign-extended per SIGNED to ACC_W. Accumulation wraps modulo 2^ACC_W; there is no saturation.
- SEND: elements go out in row-major order, ACC_W/8 bytes per element, most significant byte first.
  - out_valid=1 throughout SEND.
  - out_data holds stable while out_ready=0.
  - The byte index advances only on out_valid && out_ready.
  - On the last accepted byte, pulse done and go to IDLE.
- ERR: out_valid=1 with out_data=ERR_BYTE. On acceptance, go to IDLE; done is not pulsed.
- clear has priority over every other transition. From any state it goes to IDLE with counters zeroed, out_valid=0, and no done or err pulse. Buffer contents are don't-care.
- rst=0 mid-operation has the same effect as clear, but is immediate and asynchronous.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, busy=0, done=0, err=0, all counters 0. in_ready=1, since it is combinational from IDLE.
- Load: one byte per cycle at most. The last B byte accepted at cycle t gives state=COMPUTE at t+1.
- COMPUTE lasts exactly n³ cycles; state=SEND in the following cycle.
- First out_valid is asserted in the first SEND cycle. The first byte is registered and ready on entry.
- With out_ready held at 1, SEND lasts n*n*ACC_W/8 cycles. done is asserted in the cycle after the last handshake, coincident with state=IDLE.
- err pulses in the cycle state becomes ERR.
- A new size byte can be accepted in the first IDLE cycle after done.

## Test plan
- Unsigned 2×2, ACC_W=24: send 02, 01 02 03 04, 05 06 07 08.
  - Required output: 00 00 13 00 00 16 00 00 2B 00 00 32, then one done pulse.
  - COMPUTE lasts 8 cycles.
- Full-scale n=4, all 32 data bytes FF, SIGNED=0: sixteen elements of 03 F8 04 (4×65025 = 260100).
- SIGNED=1, n=1: A=FF, B=02 gives FF FF FE; A=80, B=80 gives 00 40 00.
- Size rejection with N_MAX=4: size 00, then separately size 05.
  - Each gives an err pulse and a single EE byte, then IDLE.
  - A following valid job then completes correctly.
- Backpressure: repeat the 2×2 job with out_ready toggling pseudo-randomly.
  - The byte sequence must be identical.
  - out_data must be stable whenever out_valid && !out_ready.
  - No byte may be duplicated or dropped.
- Abort: assert clear during LOAD_B, then separately assert rst=0 during SEND.
  - After each: state=IDLE, out_valid=0, no done.
  - A subsequent 2×2 job produces the correct 12 bytes.
